// File: rtl/mac_sat_sequencer.sv
// mac_sat_sequencer: sequences signed fixed-point multiply-accumulate over a
// stream of operand pairs, then saturates the sum to BIT_WIDTH and returns
// one result per dot product on a valid/ready handshake.
module mac_sat_sequencer #(
    parameter int unsigned BIT_WIDTH  = 16,
    parameter int unsigned FRAC_WIDTH = 8,
    parameter int unsigned MAX_LEN    = 16,
    parameter int unsigned LEN_WIDTH  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_a,
    input  logic [BIT_WIDTH-1:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_data,
    output logic                 out_sat
);

    localparam int unsigned PW = 2 * BIT_WIDTH;
    localparam int unsigned AW = 2 * BIT_WIDTH + LEN_WIDTH;
    // Bits of the accumulator from the result sign bit upward; all must agree
    // for the shifted sum to fit in BIT_WIDTH.
    localparam int unsigned RW = AW - (BIT_WIDTH + FRAC_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]          acc_q, acc_d;
    logic [PW-1:0]          prod_q, prod_d;
    logic [BIT_WIDTH-1:0]   out_data_q, out_data_d;
    logic                   out_sat_q, out_sat_d;
    logic                   out_valid_q, out_valid_d;

    logic signed [PW-1:0]   mult;
    logic [AW-1:0]          prod_ext;
    logic [AW-1:0]          acc_f;
    logic [RW-1:0]          acc_hi;
    logic                   in_range;
    logic [BIT_WIDTH-1:0]   sat_data;
    logic                   sat_flag;
    logic                   acc_f_frac_unused;
    logic [LEN_WIDTH-1:0]   eff_len;
    logic                   in_hs;

    assign busy      = (state_q != IDLE);
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    // Datapath: product, accumulate-with-pending-product, saturation.
    always_comb begin
        mult              = $signed(in_a) * $signed(in_b);
        prod_ext          = {{(AW-PW){prod_q[PW-1]}}, prod_q};
        acc_f             = acc_q + prod_ext;
        acc_hi            = acc_f[AW-1:BIT_WIDTH+FRAC_WIDTH-1];
        in_range          = (&acc_hi) | ~(|acc_hi);
        acc_f_frac_unused = ^acc_f[FRAC_WIDTH-1:0];
        if (in_range) begin
            sat_data = acc_f[BIT_WIDTH+FRAC_WIDTH-1:FRAC_WIDTH];
            sat_flag = 1'b0;
        end else if (acc_f[AW-1]) begin
            sat_data = {1'b1, {(BIT_WIDTH-1){1'b0}}};
            sat_flag = 1'b1;
        end else begin
            sat_data = {1'b0, {(BIT_WIDTH-1){1'b1}}};
            sat_flag = 1'b1;
        end
        eff_len = (len > LEN_WIDTH'(MAX_LEN)) ? LEN_WIDTH'(MAX_LEN) : len;
        in_hs   = in_valid & (state_q == ACCUM);
    end

    // Next-state and register updates for the sequencing FSM.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d  = eff_len;
                    cnt_d  = '0;
                    acc_d  = '0;
                    prod_d = '0;
                    state_d = (len == '0) ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                // The product registered last cycle is folded in now, so a
                // bubble must zero prod_q to avoid counting it twice.
                acc_d = acc_f;
                if (in_hs) begin
                    prod_d = mult;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == len_q) begin
                        state_d = DRAIN;
                    end
                end else begin
                    prod_d = '0;
                end
            end
            DRAIN: begin
                out_data_d  = sat_data;
                out_sat_d   = sat_flag;
                out_valid_d = 1'b1;
                state_d     = OUTPUT;
            end
            OUTPUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_mac_sat_sequencer.sv
// Directed testbench for mac_sat_sequencer with hand-computed expectations.
module tb_mac_sat_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  len;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sat;

    int vectors = 0;
    int miscompares = 0;

    mac_sat_sequencer #(
        .BIT_WIDTH(16),
        .FRAC_WIDTH(8),
        .MAX_LEN(16),
        .LEN_WIDTH(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .len(len),
        .busy(busy),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one pair and hold it until it is taken (bounded wait).
    task automatic feed(input logic [15:0] a, input logic [15:0] b);
        int n;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $error("FAIL feed_timeout observed=0 expected=1");
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic begin_op(input logic [4:0] l);
        start = 1'b1;
        len = l;
        tick();
        start = 1'b0;
        len = 5'd0;
    endtask

    // Wait for a result, check it, complete the handshake, check IDLE.
    task automatic finish_result(input string tag, input logic [15:0] exp_d, input logic exp_s);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(exp_d));
        check({tag, "_sat"}, 32'(out_sat), 32'(exp_s));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_vclr"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        len = '0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_sat", 32'(out_sat), 32'd0);

        // Basic sum: 1.0*3.0 + 2.0*0.5 = 4.0, latency 2 after last handshake
        begin_op(5'd2);
        check("basic_busy", 32'(busy), 32'd1);
        check("basic_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_a = 16'h0100; in_b = 16'h0300;
        tick();
        in_a = 16'h0200; in_b = 16'h0080;
        tick();
        in_valid = 1'b0;
        check("basic_drain_nov", 32'(out_valid), 32'd0);
        check("basic_drain_nrdy", 32'(in_ready), 32'd0);
        tick();
        check("basic_lat_valid", 32'(out_valid), 32'd1);
        finish_result("basic", 16'h0400, 1'b0);

        // Positive saturation
        begin_op(5'd4);
        for (int i = 0; i < 4; i++) feed(16'h7FFF, 16'h7FFF);
        finish_result("possat", 16'h7FFF, 1'b1);

        // Negative saturation: -32768*32767 >>> 8 far below -32768
        begin_op(5'd1);
        feed(16'h8000, 16'h7FFF);
        finish_result("negsat", 16'h8000, 1'b1);

        // Floor truncation: -128 >>> 8 = -1
        begin_op(5'd1);
        feed(16'hFF80, 16'h0001);
        finish_result("floor", 16'hFFFF, 1'b0);

        // Bubbles: 1.0 + 2.0 - 0.5 = 2.5 -> 0x0280, then backpressure
        begin_op(5'd3);
        in_valid = 1'b1; in_a = 16'h0100; in_b = 16'h0100; tick();
        in_valid = 1'b0; in_a = 16'h7FFF; in_b = 16'h7FFF; tick();
        tick();
        in_valid = 1'b1; in_a = 16'h0200; in_b = 16'h0100; tick();
        in_valid = 1'b0; in_a = 16'h7FFF; in_b = 16'h7FFF; tick();
        in_valid = 1'b1; in_a = 16'hFF80; in_b = 16'h0100; tick();
        in_valid = 1'b0;
        check("bub_drain_nrdy", 32'(in_ready), 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bub_stall_valid", 32'(out_valid), 32'd1);
            check("bub_stall_data", 32'(out_data), 32'h0280);
            check("bub_stall_busy", 32'(busy), 32'd1);
            tick();
        end
        finish_result("bubble", 16'h0280, 1'b0);

        // len = 0: DRAIN next cycle, result 0 two cycles after start
        begin_op(5'd0);
        check("len0_busy", 32'(busy), 32'd1);
        check("len0_in_ready", 32'(in_ready), 32'd0);
        check("len0_nov", 32'(out_valid), 32'd0);
        tick();
        check("len0_valid", 32'(out_valid), 32'd1);
        finish_result("len0", 16'h0000, 1'b0);

        // len = 31 clipped to 16 pairs of 1.0; start pulse mid-stream ignored
        begin_op(5'd31);
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                start = 1'b1;
                len = 5'd0;
            end
            feed(16'h0100, 16'h0100);
            start = 1'b0;
        end
        check("len31_rdy_low", 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_a = 16'h7FFF; in_b = 16'h7FFF;
        tick();
        check("len31_rdy_low2", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        finish_result("len31", 16'h1000, 1'b0);

        // Reset mid-operation discards the partial sum
        begin_op(5'd3);
        feed(16'h7FFF, 16'h7FFF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd0);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_out_data", 32'(out_data), 32'd0);
        check("mrst_out_sat", 32'(out_sat), 32'd0);
        begin_op(5'd1);
        feed(16'h0100, 16'h0100);
        finish_result("post_rst", 16'h0100, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
